// File: rtl/alu_seq_if.sv
// Operand/result bundle for alu_seq. The control unit is the master; the ALU is the slave.
// start is sampled only while busy=0; done pulses once when out/out_hi/flags update.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_hi;
  logic             zero;
  logic             carry;
  logic             negative;
  logic             overflow;
  logic             busy;
  logic             done;
  logic             dbg_state;

  modport master (
    output start, control, a, b,
    input  out, out_hi, zero, carry, negative, overflow, busy, done, dbg_state
  );

  modport slave (
    input  start, control, a, b,
    output out, out_hi, zero, carry, negative, overflow, busy, done, dbg_state
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with zero/carry/negative/overflow flags and a start/busy/done handshake.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier behind opcode 7.
module alu_seq #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, MUL_RUN = 1'b1} state_t;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_PASSB = 3'd3;
  localparam logic [2:0] OP_OR    = 3'd4;
  localparam logic [2:0] OP_XOR   = 3'd5;
  localparam logic [2:0] OP_ADC   = 3'd6;
  localparam int         MSB      = WIDTH - 1;

  logic [WIDTH-1:0] out_q, out_d, out_hi_q, out_hi_d;
  logic             zero_q, zero_d, carry_q, carry_d;
  logic             neg_q, neg_d, ovf_q, ovf_d, done_q, done_d;
  logic [WIDTH:0]   sum_ext, cin_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic             accept, mul_launch;

`ifdef ALU_SEQ_MUL_EN
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     step_sum;

  assign mul_launch = accept && (bus.control == 3'd7);
`else
  state_t state_q;

  assign state_q    = IDLE;
  assign mul_launch = 1'b0;
`endif

  assign accept = bus.start && (state_q == IDLE);

  // Single-cycle datapath; opcode 7 falls to the default and yields zero.
  always_comb begin
    sum_ext = '0;
    cin_ext = {{WIDTH{1'b0}}, carry_q & (bus.control == OP_ADC)};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.control)
      OP_ADD, OP_ADC: begin
        sum_ext = {1'b0, bus.a} + {1'b0, bus.b} + cin_ext;
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (bus.a[MSB] == bus.b[MSB]) && (alu_res[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        sum_ext = {1'b0, bus.a} - {1'b0, bus.b};
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (bus.a[MSB] != bus.b[MSB]) && (alu_res[MSB] != bus.a[MSB]);
      end
      OP_AND:   alu_res = bus.a & bus.b;
      OP_PASSB: alu_res = bus.b;
      OP_OR:    alu_res = bus.a | bus.b;
      OP_XOR:   alu_res = bus.a ^ bus.b;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    out_d    = out_q;
    out_hi_d = out_hi_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    if (accept && !mul_launch) begin
      out_d    = alu_res;
      out_hi_d = '0;
      zero_d   = (alu_res == '0);
      carry_d  = alu_c;
      neg_d    = alu_res[MSB];
      ovf_d    = alu_v;
      done_d   = 1'b1;
    end
`ifdef ALU_SEQ_MUL_EN
    state_d  = state_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    // Upper half of prod accumulates; lower half holds the unconsumed multiplier bits.
    step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    case (state_q)
      IDLE: begin
        if (mul_launch) begin
          mcand_d = bus.a;
          prod_d  = {{WIDTH{1'b0}}, bus.b};
          cnt_d   = '0;
          state_d = MUL_RUN;
        end
      end
      MUL_RUN: begin
        prod_d = {step_sum, prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = IDLE;
          out_d    = prod_d[WIDTH-1:0];
          out_hi_d = prod_d[2*WIDTH-1:WIDTH];
          zero_d   = (prod_d[WIDTH-1:0] == '0);
          neg_d    = prod_d[WIDTH-1];
          carry_d  = (prod_d[2*WIDTH-1:WIDTH] != '0);
          ovf_d    = (prod_d[2*WIDTH-1:WIDTH] != '0);
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q    <= '0;
      out_hi_q <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

  assign bus.out       = out_q;
  assign bus.out_hi    = out_hi_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.negative  = neg_q;
  assign bus.overflow  = ovf_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q == MUL_RUN);
  assign bus.dbg_state = (state_q == MUL_RUN);
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised successor to the processor's 8-bit combinational ALU.
- Adds a flags register (zero, carry, negative, overflow), add-with-carry, and OR/XOR.
- Adds an optional iterative shift-add multiplier.
- Sits in the datapath between the register/stack operands and the writeback mux.
- Uses a start/busy/done handshake so the control unit can stall on multi-cycle ops.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 4).
- CNT_W, $clog2(WIDTH)+1, width of the internal multiply iteration counter (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request an operation; sampled only when busy=0.
- control  input  3  opcode, sampled with start.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- out  output  WIDTH  registered result (low half for MUL).
- out_hi  output  WIDTH  high half of MUL product; 0 for all other ops.
- zero  output  1  registered flag: out == 0 (out_hi ignored).
- carry  output  1  registered carry/borrow flag.
- negative  output  1  registered flag: out[WIDTH-1].
- overflow  output  1  registered signed-overflow flag.
- busy  output  1  high while a multi-cycle op is in progress.
- done  output  1  one-cycle pulse when out and flags update.

Behaviour:
- Reset (async, active-high): out=0, out_hi=0, zero=1, carry=0, negative=0, overflow=0, busy=0, done=0, FSM=IDLE.
- Reset asserted mid-MUL aborts the op with no done pulse.
- Opcodes; 0-3 keep the legacy encoding:
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 AND.
  - 3 PASSB: out=b.
  - 4 OR.
  - 5 XOR.
  - 6 ADC: a+b+carry, using the carry flag value at the sampling edge.
  - 7 MUL.
- Arithmetic is modulo 2^WIDTH.
- ADD/ADC flags: carry = bit WIDTH of the (WIDTH+1)-bit sum; overflow = a,b same sign and result sign differs.
- SUB flags: carry = borrow (1 iff a < b unsigned); overflow = a,b signs differ and result sign differs from a.
- AND/OR/XOR/PASSB flags: carry=0, overflow=0.
- zero and negative always follow the new out.
- FSM states: IDLE, MUL_RUN.
- IDLE, start=1, opcode 0-6: at the sampling edge, out/out_hi/flags update and done=1 for the following cycle. Latency 1, throughput 1 op/cycle; back-to-back starts are allowed.
- IDLE, start=1, opcode 7 (MUL_EN defined):
  - At the sampling edge, latch a and b, clear the accumulator, set busy=1, enter MUL_RUN.
  - MUL_RUN processes one multiplier bit per cycle (LSB first) for WIDTH cycles.
  - On the WIDTH-th edge after acceptance: busy=0, done=1, out=product[WIDTH-1:0], out_hi=product[2*WIDTH-1:WIDTH], carry=overflow=(out_hi!=0), state returns to IDLE.
- start while busy=1 is ignored: no queueing, operands discarded.
- start may be asserted on the same cycle busy falls; it is accepted at the next edge.
- Between completions, out, out_hi and flags hold their values; done is 0.
- done is never high for more than one cycle per operation.
- Unsigned multiply only.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: MUL_RUN state, multiplicand/multiplier/accumulator registers and the iteration counter are built; opcode 7 behaves as above.
- Undefined: no multiplier logic and busy is tied 0. Opcode 7 completes in 1 cycle with out=0, out_hi=0, zero=1, carry=0, overflow=0, negative=0, done=1.

Test Plan:
- Reset check: assert reset mid-cycle (async) -> out=0, zero=1, busy=0, done=0 immediately, without waiting for a clock edge.
- ADD wrap (WIDTH=8): start, op0, a=0xF0, b=0x20 -> next cycle out=0x10, carry=1, overflow=0, done=1 for exactly 1 cycle.
- SUB, then ADC chain:
  - op1, a=0x05, b=0x07 -> out=0xFE, carry=1, negative=1.
  - Next cycle op6, a=0x01, b=0x01 -> out=0x03.
- Signed overflow and zero:
  - op0, a=0x7F, b=0x01 -> out=0x80, overflow=1, negative=1.
  - op5, a=0x5A, b=0x5A -> out=0x00, zero=1, carry=0.
- MUL (macro on):
  - op7, a=0xFF, b=0xFF -> busy=1 for 8 cycles; start pulses during busy are ignored.
  - done on cycle 8 with out=0x01, out_hi=0xFE, carry=overflow=1.
  - Reset at cycle 4 of a second MUL -> no done pulse; outputs return to reset values.
- MUL (macro off): op7, a=0x12, b=0x34 -> 1-cycle done, out=0, out_hi=0, zero=1, busy never asserted.
